// File: rtl/axi_stream_protocol_checker_if.sv
// AXI4-Stream link bundle; the checker attaches through the read-only monitor modport.
interface axi_stream_protocol_checker_if #(
  parameter int unsigned BYTE_WIDTH = 4,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned DEST_WIDTH = 1,
  parameter int unsigned USER_WIDTH = 1
);
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic [8*BYTE_WIDTH-1:0] tdata;
  logic [BYTE_WIDTH-1:0]   tstrb;
  logic [BYTE_WIDTH-1:0]   tkeep;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;

  modport master (
    output tvalid, tlast, tdata, tstrb, tkeep, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tlast, tdata, tstrb, tkeep, tid, tdest, tuser,
    output tready
  );

  modport monitor (
    input tvalid, tready, tlast, tdata, tstrb, tkeep, tid, tdest, tuser
  );
endinterface

// File: rtl/axi_stream_protocol_checker.sv
// Passive AXI4-Stream protocol checker: sticky violation flags, first-error index
// and saturating beat/packet/byte counters. Never drives the observed link.
module axi_stream_protocol_checker #(
  parameter int unsigned byte_width       = 4,
  parameter int unsigned id_width         = 1,
  parameter int unsigned dest_width       = 1,
  parameter int unsigned user_width       = 1,
  parameter bit          has_tready       = 1'b1,
  parameter bit          has_tlast        = 1'b1,
  parameter int unsigned max_stall        = 16,
  parameter int unsigned max_packet_beats = 0,
  parameter bit          allow_interleave = 1'b0,
  parameter int unsigned cnt_width        = 32
) (
  input  logic                              clk,
  input  logic                              resetn,
  axi_stream_protocol_checker_if.monitor    bus,
  input  logic                              clear,
  output logic [6:0]                        err_flags,
  output logic                              err_any,
  output logic [2:0]                        first_err,
  output logic                              in_packet,
  output logic [cnt_width-1:0]              beat_count,
  output logic [cnt_width-1:0]              packet_count,
  output logic [cnt_width-1:0]              byte_count
);

  localparam int unsigned DATA_W    = 8 * byte_width;
  localparam int unsigned PAY_W     = DATA_W + 2 * byte_width + 1 + id_width + dest_width + user_width;
  localparam int unsigned STALL_W   = (max_stall < 2) ? 1 : $clog2(max_stall + 1);
  localparam int unsigned STALL_LIM = (max_stall == 0) ? 0 : max_stall - 1;
  localparam int unsigned PB_W      = (max_packet_beats < 2) ? 1 : $clog2(max_packet_beats + 1);
  localparam int unsigned PB_LIM    = (max_packet_beats == 0) ? 0 : max_packet_beats - 1;
  localparam int unsigned POP_W     = $clog2(byte_width + 1);
  localparam int unsigned SUM_W     = cnt_width + 1;

  localparam logic [0:0]           ST_IDLE = 1'b0;
  localparam logic [0:0]           ST_PKT  = 1'b1;
  localparam logic [2:0]           NO_ERR  = 3'd7;
  localparam logic [cnt_width-1:0] CNT_MAX = '1;
  localparam logic [PB_W-1:0]      PB_MAX  = '1;

  logic                  ready_c, last_c, hs_c;
  logic [PAY_W-1:0]      pay_c;
  logic [POP_W-1:0]      keep_pop_c;
  logic [SUM_W-1:0]      byte_sum_c;
  logic [PB_W-1:0]       beats_cur_c;
  logic [6:0]            set_c, new_c;

  logic [0:0]            state_q, state_d;
  logic [PB_W-1:0]       pkt_beats_q, pkt_beats_d;
  logic [id_width-1:0]   cap_tid_q, cap_tid_d;
  logic [dest_width-1:0] cap_tdest_q, cap_tdest_d;
  logic [STALL_W-1:0]    stall_q, stall_d;
  logic                  fresh_q;
  logic                  prev_valid_q, prev_ready_q;
  logic [PAY_W-1:0]      prev_pay_q;
  logic [6:0]            flags_q, flags_d;
  logic [2:0]            first_err_q, first_err_d;
  logic                  err_any_q, err_any_d;
  logic [cnt_width-1:0]  beat_q, beat_d, pkt_cnt_q, pkt_cnt_d, byte_q, byte_d;

  assign ready_c = has_tready ? bus.tready : 1'b1;
  assign last_c  = has_tlast  ? bus.tlast  : 1'b1;
  assign hs_c    = bus.tvalid && ready_c;
  assign pay_c   = {bus.tdata, bus.tstrb, bus.tkeep, last_c, bus.tid, bus.tdest, bus.tuser};

  always_comb begin
    keep_pop_c = '0;
    for (int i = 0; i < int'(byte_width); i++) begin
      keep_pop_c = keep_pop_c + POP_W'(bus.tkeep[i]);
    end
  end

  // Next-state: packet FSM, stall run, violation detection and counters
  always_comb begin
    state_d     = state_q;
    pkt_beats_d = pkt_beats_q;
    cap_tid_d   = cap_tid_q;
    cap_tdest_d = cap_tdest_q;
    stall_d     = stall_q;
    set_c       = '0;
    new_c       = '0;
    flags_d     = flags_q;
    first_err_d = first_err_q;
    err_any_d   = err_any_q;
    beat_d      = beat_q;
    pkt_cnt_d   = pkt_cnt_q;
    byte_d      = byte_q;
    beats_cur_c = (state_q == ST_PKT) ? pkt_beats_q : '0;
    byte_sum_c  = {1'b0, byte_q} + SUM_W'(keep_pop_c);

    if (hs_c) begin
      if (last_c) begin
        state_d     = ST_IDLE;
        pkt_beats_d = '0;
      end else if (state_q == ST_IDLE) begin
        state_d     = ST_PKT;
        pkt_beats_d = PB_W'(1);
        cap_tid_d   = bus.tid;
        cap_tdest_d = bus.tdest;
      end else if (pkt_beats_q != PB_MAX) begin
        pkt_beats_d = pkt_beats_q + PB_W'(1);
      end
    end

    if (has_tready && (max_stall != 0)) begin
      if (bus.tvalid && !ready_c) begin
        if (stall_q != STALL_W'(max_stall)) stall_d = stall_q + STALL_W'(1);
      end else begin
        stall_d = '0;
      end
    end

    // Previous-sample checks are meaningless on the first edge out of reset
    set_c[0] = !fresh_q && prev_valid_q && !prev_ready_q && !bus.tvalid;
    set_c[1] = !fresh_q && prev_valid_q && !prev_ready_q && bus.tvalid && (pay_c != prev_pay_q);
    set_c[2] = bus.tvalid && (|(bus.tstrb & ~bus.tkeep));
    set_c[3] = fresh_q && bus.tvalid;
    set_c[4] = has_tready && (max_stall != 0) && bus.tvalid && !ready_c
               && (stall_q >= STALL_W'(STALL_LIM));
    set_c[5] = (max_packet_beats != 0) && hs_c && !last_c && (beats_cur_c == PB_W'(PB_LIM));
    set_c[6] = !allow_interleave && (state_q == ST_PKT) && hs_c
               && ((bus.tid != cap_tid_q) || (bus.tdest != cap_tdest_q));

    new_c   = set_c & ~flags_q;
    flags_d = flags_q | set_c;
    if (first_err_q == NO_ERR) begin
      for (int i = 6; i >= 0; i--) begin
        if (new_c[i]) first_err_d = 3'(i);
      end
    end

    if (hs_c && (beat_q != CNT_MAX)) beat_d = beat_q + cnt_width'(1);
    if (hs_c && last_c && (pkt_cnt_q != CNT_MAX)) pkt_cnt_d = pkt_cnt_q + cnt_width'(1);
    if (hs_c) byte_d = byte_sum_c[cnt_width] ? CNT_MAX : byte_sum_c[cnt_width-1:0];

    if (clear) begin
      flags_d     = '0;
      first_err_d = NO_ERR;
      beat_d      = '0;
      pkt_cnt_d   = '0;
      byte_d      = '0;
    end
    err_any_d = |flags_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      pkt_beats_q  <= '0;
      cap_tid_q    <= '0;
      cap_tdest_q  <= '0;
      stall_q      <= '0;
      fresh_q      <= 1'b1;
      prev_valid_q <= 1'b0;
      prev_ready_q <= 1'b0;
      prev_pay_q   <= '0;
      flags_q      <= '0;
      first_err_q  <= NO_ERR;
      err_any_q    <= 1'b0;
      beat_q       <= '0;
      pkt_cnt_q    <= '0;
      byte_q       <= '0;
    end else begin
      state_q      <= state_d;
      pkt_beats_q  <= pkt_beats_d;
      cap_tid_q    <= cap_tid_d;
      cap_tdest_q  <= cap_tdest_d;
      stall_q      <= stall_d;
      fresh_q      <= 1'b0;
      prev_valid_q <= bus.tvalid;
      prev_ready_q <= ready_c;
      prev_pay_q   <= pay_c;
      flags_q      <= flags_d;
      first_err_q  <= first_err_d;
      err_any_q    <= err_any_d;
      beat_q       <= beat_d;
      pkt_cnt_q    <= pkt_cnt_d;
      byte_q       <= byte_d;
    end
  end

  assign err_flags    = flags_q;
  assign err_any      = err_any_q;
  assign first_err    = first_err_q;
  assign in_packet    = (state_q == ST_PKT);
  assign beat_count   = beat_q;
  assign packet_count = pkt_cnt_q;
  assign byte_count   = byte_q;

endmodule

// File: tb/tb_axi_stream_protocol_checker.sv
// Directed + randomized bench for axi_stream_protocol_checker against a
// cycle-level behavioural model of the protocol rules.
module tb_axi_stream_protocol_checker;
  localparam int unsigned BW   = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned DW   = 2;
  localparam int unsigned UW   = 1;
  localparam int unsigned CW   = 4;
  localparam int unsigned MS   = 16;
  localparam int unsigned MPB  = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic resetn, clear;
  logic [6:0]    err_flags;
  logic          err_any, in_packet;
  logic [2:0]    first_err;
  logic [CW-1:0] beat_count, packet_count, byte_count;

  always #5 clk = ~clk;

  axi_stream_protocol_checker_if #(.BYTE_WIDTH(BW), .ID_WIDTH(IDW),
                                   .DEST_WIDTH(DW), .USER_WIDTH(UW)) bus ();

  axi_stream_protocol_checker #(
    .byte_width(BW), .id_width(IDW), .dest_width(DW), .user_width(UW),
    .has_tready(1'b1), .has_tlast(1'b1), .max_stall(MS),
    .max_packet_beats(MPB), .allow_interleave(1'b0), .cnt_width(CW)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .clear(clear),
    .err_flags(err_flags), .err_any(err_any), .first_err(first_err),
    .in_packet(in_packet), .beat_count(beat_count),
    .packet_count(packet_count), .byte_count(byte_count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state: what the observer must know after each edge
  typedef struct packed {
    logic [6:0]      flags;
    logic [2:0]      first;
    logic            in_pkt;
    logic [31:0]     beats;
    logic [IDW-1:0]  cid;
    logic [DW-1:0]   cdest;
    logic [31:0]     stall_run;
    logic [31:0]     beat_cnt;
    logic [31:0]     pkt_cnt;
    logic [31:0]     byte_cnt;
    logic            fresh;
    logic            p_valid;
    logic            p_ready;
    logic [8*BW-1:0] p_data;
    logic [BW-1:0]   p_strb;
    logic [BW-1:0]   p_keep;
    logic            p_last;
    logic [IDW-1:0]  p_id;
    logic [DW-1:0]   p_dest;
    logic [UW-1:0]   p_user;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t s;
    s       = '0;
    s.first = 3'd7;
    s.fresh = 1'b1;
    return s;
  endfunction

  function automatic model_t model_step(input model_t s);
    model_t     n;
    logic [6:0] ev;
    logic       hs, same;
    int         beat_no;
    n  = s;
    ev = '0;
    hs = bus.tvalid && bus.tready;
    same = (bus.tdata == s.p_data) && (bus.tstrb == s.p_strb) && (bus.tkeep == s.p_keep)
           && (bus.tlast == s.p_last) && (bus.tid == s.p_id) && (bus.tdest == s.p_dest)
           && (bus.tuser == s.p_user);
    if (!s.fresh && s.p_valid && !s.p_ready) begin
      if (!bus.tvalid) ev[0] = 1'b1;
      else if (!same)  ev[1] = 1'b1;
    end
    if (bus.tvalid && ((bus.tstrb & ~bus.tkeep) != '0)) ev[2] = 1'b1;
    if (s.fresh && bus.tvalid) ev[3] = 1'b1;
    if (bus.tvalid && !bus.tready) n.stall_run = s.stall_run + 1;
    else n.stall_run = 0;
    if (n.stall_run >= MS) ev[4] = 1'b1;
    if (hs) begin
      if (s.in_pkt && ((bus.tid != s.cid) || (bus.tdest != s.cdest))) ev[6] = 1'b1;
      beat_no = s.in_pkt ? int'(s.beats) + 1 : 1;
      if (!bus.tlast && beat_no == MPB) ev[5] = 1'b1;
      if (bus.tlast) begin
        n.in_pkt = 1'b0;
        n.beats  = 0;
      end else begin
        if (!s.in_pkt) begin
          n.cid   = bus.tid;
          n.cdest = bus.tdest;
        end
        n.in_pkt = 1'b1;
        n.beats  = 32'(beat_no);
      end
      if (s.beat_cnt < CMAX) n.beat_cnt = s.beat_cnt + 1;
      if (bus.tlast && s.pkt_cnt < CMAX) n.pkt_cnt = s.pkt_cnt + 1;
      n.byte_cnt = s.byte_cnt + 32'($countones(bus.tkeep));
      if (n.byte_cnt > CMAX) n.byte_cnt = CMAX;
    end
    if (clear) begin
      n.flags    = '0;
      n.first    = 3'd7;
      n.beat_cnt = 0;
      n.pkt_cnt  = 0;
      n.byte_cnt = 0;
    end else begin
      if (s.first == 3'd7) begin
        for (int i = 6; i >= 0; i--) if (ev[i] && !s.flags[i]) n.first = 3'(i);
      end
      n.flags = s.flags | ev;
    end
    n.fresh   = 1'b0;
    n.p_valid = bus.tvalid;
    n.p_ready = bus.tready;
    n.p_data  = bus.tdata;
    n.p_strb  = bus.tstrb;
    n.p_keep  = bus.tkeep;
    n.p_last  = bus.tlast;
    n.p_id    = bus.tid;
    n.p_dest  = bus.tdest;
    n.p_user  = bus.tuser;
    return n;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) m <= model_reset();
    else         m <= model_step(m);
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("err_flags",    32'(err_flags),    32'(m.flags));
      chk("err_any",      32'(err_any),      32'(|m.flags));
      chk("first_err",    32'(first_err),    32'(m.first));
      chk("in_packet",    32'(in_packet),    32'(m.in_pkt));
      chk("beat_count",   32'(beat_count),   m.beat_cnt);
      chk("packet_count", 32'(packet_count), m.pkt_cnt);
      chk("byte_count",   32'(byte_count),   m.byte_cnt);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  int  burst;
  bit  hold;

  initial begin
    resetn      = 1'b0;
    clear       = 1'b0;
    bus.tvalid  = 1'b0;
    bus.tready  = 1'b1;
    bus.tlast   = 1'b0;
    bus.tdata   = '0;
    bus.tstrb   = 4'hF;
    bus.tkeep   = 4'hF;
    bus.tid     = '0;
    bus.tdest   = '0;
    bus.tuser   = '0;
    cyc();
    cyc();
    cmp_en = 1'b1;
    resetn = 1'b1;
    chk("reset_flags", 32'(err_flags), 32'd0);
    chk("reset_first", 32'(first_err), 32'd7);
    chk("reset_beats", 32'(beat_count), 32'd0);
    cyc();

    // Three-beat packet
    for (int b = 1; b <= 3; b++) begin
      bus.tvalid = 1'b1;
      bus.tlast  = (b == 3);
      bus.tdata  = 32'($urandom);
      cyc();
      if (b == 1) chk("pkt_inpacket_mid", 32'(in_packet), 32'd1);
    end
    bus.tvalid = 1'b0;
    bus.tlast  = 1'b0;
    chk("pkt_beats",   32'(beat_count),   32'd3);
    chk("pkt_bytes",   32'(byte_count),   32'd12);
    chk("pkt_packets", 32'(packet_count), 32'd1);
    chk("pkt_flags",   32'(err_flags),    32'd0);
    chk("pkt_inpkt",   32'(in_packet),    32'd0);
    chk("model_bytes", m.byte_cnt,        32'd12);
    do_clear();

    // Payload change while stalled
    bus.tvalid = 1'b1; bus.tready = 1'b0; bus.tdata = 32'hA5;
    cyc();
    chk("pc_first_stall", 32'(err_flags), 32'd0);
    bus.tdata = 32'h5A;
    cyc();
    chk("pc_flags", 32'(err_flags), 32'h02);
    chk("pc_first", 32'(first_err), 32'd1);
    chk("pc_any",   32'(err_any),   32'd1);
    bus.tready = 1'b1;
    cyc();
    bus.tlast = 1'b1;
    cyc();
    bus.tvalid = 1'b0; bus.tlast = 1'b0;
    cyc();
    do_clear();

    // Valid dropped after a stall, then clear
    bus.tvalid = 1'b1; bus.tready = 1'b0; bus.tlast = 1'b1;
    cyc();
    bus.tvalid = 1'b0;
    cyc();
    chk("drop_flags", 32'(err_flags), 32'h01);
    chk("drop_first", 32'(first_err), 32'd0);
    do_clear();
    chk("clr_flags", 32'(err_flags), 32'd0);
    chk("clr_first", 32'(first_err), 32'd7);
    chk("clr_any",   32'(err_any),   32'd0);

    // Stall timeout exactly at edge MS
    bus.tvalid = 1'b1; bus.tready = 1'b0; bus.tlast = 1'b1;
    for (int i = 0; i < int'(MS) - 1; i++) cyc();
    chk("stall_15", 32'(err_flags), 32'd0);
    cyc();
    chk("stall_16",       32'(err_flags), 32'h10);
    chk("stall_16_first", 32'(first_err), 32'd4);
    bus.tready = 1'b1;
    cyc();
    bus.tvalid = 1'b0;
    cyc();
    do_clear();

    // Packet too long
    bus.tvalid = 1'b1; bus.tready = 1'b1; bus.tlast = 1'b0; bus.tid = '0; bus.tdest = '0;
    for (int i = 0; i < int'(MPB) - 1; i++) cyc();
    chk("long_3", 32'(err_flags), 32'd0);
    cyc();
    chk("long_4",       32'(err_flags), 32'h20);
    chk("long_4_first", 32'(first_err), 32'd5);
    bus.tlast = 1'b1;
    cyc();
    bus.tvalid = 1'b0;
    do_clear();

    // Interleave: TID changes on beat 2
    bus.tvalid = 1'b1; bus.tlast = 1'b0; bus.tid = 2'd0;
    cyc();
    bus.tid = 2'd1;
    cyc();
    chk("ilv_flags", 32'(err_flags), 32'h40);
    chk("ilv_first", 32'(first_err), 32'd6);
    bus.tlast = 1'b1;
    cyc();
    bus.tvalid = 1'b0; bus.tid = 2'd0;
    do_clear();

    // Strobe outside keep
    bus.tvalid = 1'b1; bus.tlast = 1'b1; bus.tstrb = 4'h1; bus.tkeep = 4'h0;
    cyc();
    chk("strb_flags", 32'(err_flags), 32'h04);
    chk("strb_first", 32'(first_err), 32'd2);
    bus.tvalid = 1'b0; bus.tstrb = 4'hF; bus.tkeep = 4'hF;
    do_clear();

    // Counter saturation, then asynchronous reset mid-packet
    bus.tvalid = 1'b1; bus.tlast = 1'b1;
    for (int i = 0; i < 17; i++) cyc();
    chk("sat_beats",   32'(beat_count),   32'd15);
    chk("sat_packets", 32'(packet_count), 32'd15);
    chk("sat_bytes",   32'(byte_count),   32'd15);
    bus.tlast = 1'b0;
    cyc();
    chk("rst_pre_inpkt", 32'(in_packet), 32'd1);
    #1 resetn = 1'b0;
    #1;
    chk("rst_inpkt", 32'(in_packet),  32'd0);
    chk("rst_beats", 32'(beat_count), 32'd0);
    chk("rst_first", 32'(first_err),  32'd7);
    chk("rst_flags", 32'(err_flags),  32'd0);
    bus.tvalid = 1'b0;
    resetn     = 1'b1;
    cyc();

    // Randomized traffic with occasional violations, clears and resets
    burst = 0;
    for (int c = 0; c < 4000; c++) begin
      hold = bus.tvalid && !bus.tready && ($urandom_range(0, 19) != 0);
      if (!hold) begin
        bus.tvalid = ($urandom_range(0, 9) < 7);
        bus.tdata  = 32'($urandom);
        bus.tkeep  = 4'($urandom);
        bus.tstrb  = ($urandom_range(0, 15) == 0) ? 4'($urandom) : (bus.tkeep & 4'($urandom));
        bus.tlast  = ($urandom_range(0, 3) == 0);
        bus.tuser  = 1'($urandom);
        if ($urandom_range(0, 15) == 0) bus.tid   = 2'($urandom);
        if ($urandom_range(0, 31) == 0) bus.tdest = 2'($urandom);
      end
      if (burst > 0) begin
        bus.tready = 1'b0;
        burst--;
      end else if ($urandom_range(0, 99) == 0) begin
        burst      = $urandom_range(10, 24);
        bus.tready = 1'b0;
      end else begin
        bus.tready = ($urandom_range(0, 3) != 0);
      end
      clear = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #1 resetn = 1'b0;
        #1 resetn = 1'b1;
      end
      cyc();
    end
    clear      = 1'b0;
    bus.tvalid = 1'b0;
    cyc();
    cyc();
    cmp_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_stream_protocol_checker.md
# axi_stream_protocol_checker

Synthesizable AXI4-Stream protocol checker and traffic counter that passively observes one stream link and reports violations through sticky error flags instead of formal assumptions. It generalises the stream slave property set: configurable payload widths, optional TREADY/TLAST, stall timeout, maximum packet length and a no-interleave mode. It sits beside any stream interface (simulation, FPGA debug, or CSR-attached monitor) and never drives the bus.

## Interface
- byte_width, 4: TDATA bytes; TSTRB/TKEEP width.
- id_width, 1: TID width (≥1; tie off unused).
- dest_width, 1: TDEST width (≥1).
- user_width, 1: TUSER width (≥1).
- has_tready, 1: 0 treats tready as constant 1.
- has_tlast, 1: 0 treats tlast as constant 1 (every beat is a packet).
- max_stall, 16: stall-timeout cycles; 0 disables check.
- max_packet_beats, 0: beat limit per packet; 0 disables check.
- allow_interleave, 0: 0 flags TID/TDEST change mid-packet.
- cnt_width, 32: width of all counters.

- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- tvalid, tready, tlast  in  1  observed stream controls.
- tdata  in  8*byte_width; tstrb, tkeep  in  byte_width; tid  in  id_width; tdest  in  dest_width; tuser  in  user_width: observed payload.
- clear  in  1  synchronous clear of counters and flags.
- err_flags  out  7  sticky violation bits (see Operation).
- err_any  out  1  OR of err_flags.
- first_err  out  3  index of first bit set since reset/clear; 7 = none.
- in_packet  out  1  FSM in PKT state.
- beat_count, packet_count, byte_count  out  cnt_width  traffic counters.

## Operation
- Handshake (hs) = tvalid && tready at a clk edge.
- FSM: IDLE, PKT. hs && !tlast: IDLE→PKT, capture tid/tdest, pkt_beats=1; in PKT, pkt_beats+=1 (saturating). hs && tlast → IDLE from either state. Reset → IDLE.
- Error bits (set at the edge where the condition is sampled; sticky until clear or reset):
  - 0 VALID_DROP: tvalid low now, high and not hs at previous edge.
  - 1 PAYLOAD_CHANGE: previous edge tvalid && !tready, current tvalid high, and any of tdata/tstrb/tkeep/tlast/tid/tdest/tuser differs from previous sample.
  - 2 STRB_NO_KEEP: tvalid && |(tstrb & ~tkeep).
  - 3 RESET_VALID: tvalid high at first edge after resetn deasserts.
  - 4 STALL_TIMEOUT: tvalid && !tready for max_stall consecutive edges (stall counter clears on hs or !tvalid).
  - 5 PKT_TOO_LONG: hs && !tlast with pkt_beats already equal to max_packet_beats-1 (i.e. beat max_packet_beats arrives without tlast).
  - 6 INTERLEAVE: allow_interleave=0, in PKT, hs with tid or tdest ≠ captured values.
- first_err latches the lowest-indexed bit among those newly set at the first flagging edge; holds until clear/reset.
- Counters: beat_count += hs; packet_count += hs && tlast; byte_count += popcount(tkeep) on hs. All saturate at 2^cnt_width-1.
- Disabled checks (parameter 0 / has_tready=0) never set their bit.
- Passive: no outputs feed the observed link.

## Timing
- resetn low asynchronously forces: err_flags=0, err_any=0, first_err=7, in_packet=0, all counters 0, FSM IDLE, stall counter 0, previous-sample registers 0.
- All outputs registered; an event sampled at edge N is visible after edge N (latency 1).
- clear has priority: at an edge with clear=1, flags/first_err/counters load reset values and same-edge events are dropped. FSM, stall counter and previous-sample registers are not affected by clear.
- Reset mid-packet: FSM returns to IDLE; no violation recorded for the abandoned packet.
- Saturated counters hold; no wrap.
- Previous-sample comparisons (bits 0, 1) are suppressed at the first edge after reset.

## Test plan
- Reset, then 3 beats, tkeep=4'hF, last on beat 3, tready=1 → beat_count=3, byte_count=12, packet_count=1, err_flags=0, in_packet=0.
- tvalid held 2 cycles with tready=0, tdata changes 0xA5→0x5A on second → err_flags[1]=1, first_err=1 one cycle later.
- tvalid drops after 1 stall cycle without hs → err_flags[0]=1; then clear=1 → all flags 0, first_err=7.
- max_stall=16, tvalid=1, tready=0 for 16 edges → err_flags[4] rises after edge 16, not after 15.
- max_packet_beats=4, 4 beats no tlast → err_flags[5]=1; beat 2 with tid change → err_flags[6]=1; tstrb=4'h1, tkeep=4'h0 → err_flags[2]=1.
- cnt_width=4, 17 single-beat packets → beat_count=packet_count=15 (saturated); resetn pulse mid-packet → all outputs reset immediately.
